// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: FSM states, opcode/funct fields, ALU op codes
// and datapath mux select values.
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_ADDR,
    S_MEM,
    S_WB_MEM,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_AND = 2;
  localparam int unsigned ALU_OR  = 3;
  localparam int unsigned ALU_SLT = 4;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] SRC_B_RT      = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

endpackage

// File: rtl/alu_decode.sv
// Combinational R-type funct decoder: funct -> ALU operation plus a valid flag.
// An unknown funct yields ADD with valid low.
module alu_decode
  import mips_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic [5:0]          funct,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                valid
);

  always_comb begin
    alu_op = ALU_OP_W'(ALU_ADD);
    valid  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_OP_W'(ALU_ADD);
      FN_SUB:  alu_op = ALU_OP_W'(ALU_SUB);
      FN_AND:  alu_op = ALU_OP_W'(ALU_AND);
      FN_OR:   alu_op = ALU_OP_W'(ALU_OR);
      FN_SLT:  alu_op = ALU_OP_W'(ALU_SLT);
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle MIPS control FSM with memory handshake, bus timeout and illegal trap.
// Optional performance counters are built when CONTROL_PERFCNT_EN is defined.
//
// state      | meaning
// S_IDLE     | reset, datapath quiet
// S_FETCH    | instruction read, IR/PC latch on ack
// S_DECODE   | opcode dispatch, branch target into ALUOut
// S_EXEC_R   | R-type ALU operation
// S_WB_R     | R-type result to rd
// S_EXEC_I   | addi ALU operation
// S_WB_I     | addi result to rt
// S_ADDR     | lw/sw effective address
// S_MEM      | data read/write, waits for ack
// S_WB_MEM   | loaded data to rt
// S_BRANCH   | beq compare and conditional PC update
// S_JUMP     | jump target to PC
// S_TRAP     | illegal instruction or bus error, held until reset
module control_fsm
  import mips_pkg::*;
#(
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_CNT_W    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op_code,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                illegal,
  output logic                bus_err,
  output logic                busy
`ifdef CONTROL_PERFCNT_EN
 ,output logic [31:0]         instr_count,
  output logic [31:0]         stall_count
`endif
);

  state_e              state_q, state_d;
  logic [TO_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                is_sw_q, is_sw_d;
  logic                illegal_q, illegal_d;
  logic                bus_err_q, bus_err_d;
  logic [ALU_OP_W-1:0] dec_op;
  logic                dec_valid;

  alu_decode #(.ALU_OP_W(ALU_OP_W)) u_alu_decode (
    .funct  (funct),
    .alu_op (dec_op),
    .valid  (dec_valid)
  );

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    is_sw_d       = is_sw_q;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_RT;
    alu_op        = ALU_OP_W'(ALU_ADD);
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRC_B_IMM_SH2;
        is_sw_d   = (op_code == OP_SW);
        case (op_code)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_EXEC_I;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = dec_op;
        if (dec_valid) begin
          state_d = S_WB_R;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_WB_R: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_I, S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        state_d   = (state_q == S_ADDR) ? S_MEM : S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = is_sw_q;
        if (mem_ack) state_d = is_sw_q ? S_FETCH : S_WB_MEM;
      end
      S_WB_MEM: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_W'(ALU_SUB);
        pc_write_cond = 1'b1;
        pc_src        = PC_SRC_ALUOUT;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase

    // One counter serves both wait states; an ack in the limit cycle wins.
    if (mem_req && !mem_ack) begin
      if (MEM_TIMEOUT != 0 && wait_cnt_q == TO_CNT_W'(MEM_TIMEOUT - 1)) begin
        state_d    = S_TRAP;
        bus_err_d  = 1'b1;
        wait_cnt_d = '0;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end else begin
      wait_cnt_d = '0;
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign busy    = (state_q != S_IDLE) && (state_q != S_TRAP);

`ifdef CONTROL_PERFCNT_EN
  logic [31:0] instr_count_q, instr_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    instr_count_d = instr_count_q;
    stall_count_d = stall_count_q;
    if (state_q != S_TRAP) begin
      if (state_d == S_FETCH && state_q != S_IDLE && state_q != S_FETCH)
        instr_count_d = instr_count_q + 32'd1;
      if (mem_req && !mem_ack)
        stall_count_d = stall_count_q + 32'd1;
    end
  end

  assign instr_count = instr_count_q;
  assign stall_count = stall_count_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      is_sw_q       <= 1'b0;
      illegal_q     <= 1'b0;
      bus_err_q     <= 1'b0;
`ifdef CONTROL_PERFCNT_EN
      instr_count_q <= '0;
      stall_count_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      is_sw_q       <= is_sw_d;
      illegal_q     <= illegal_d;
      bus_err_q     <= bus_err_d;
`ifdef CONTROL_PERFCNT_EN
      instr_count_q <= instr_count_d;
      stall_count_q <= stall_count_d;
`endif
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-instruction cycle expectations derived from the
// instruction semantics, directed cases plus a randomized instruction stream.
module tb_control_fsm;

  localparam int TO = 16;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_dst, mem_to_reg, reg_write, illegal, bus_err, busy;
  } out_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op_code = '0, funct = '0;
  logic       zero = 1'b0, mem_ack = 1'b0;

  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_src, alu_src_b;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal, bus_err, busy;
  logic [3:0] alu_op;

  logic       z_mem_req, z_mem_we, z_iord, z_ir_write, z_pc_write, z_pc_write_cond;
  logic [1:0] z_pc_src, z_alu_src_b;
  logic       z_alu_src_a, z_reg_dst, z_mem_to_reg, z_reg_write, z_illegal, z_bus_err, z_busy;
  logic [3:0] z_alu_op;
`ifdef CONTROL_PERFCNT_EN
  logic [31:0] instr_count, stall_count, z_instr_count, z_stall_count;
`endif

  control_fsm #(.ALU_OP_W(4), .MEM_TIMEOUT(TO), .TO_CNT_W(5)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal(illegal), .bus_err(bus_err), .busy(busy)
`ifdef CONTROL_PERFCNT_EN
   ,.instr_count(instr_count), .stall_count(stall_count)
`endif
  );

  // Same stimulus, timeout disabled.
  control_fsm #(.ALU_OP_W(4), .MEM_TIMEOUT(0), .TO_CNT_W(5)) dut0 (
    .clk(clk), .reset(reset), .op_code(op_code), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(z_mem_req), .mem_we(z_mem_we), .iord(z_iord),
    .ir_write(z_ir_write), .pc_write(z_pc_write), .pc_write_cond(z_pc_write_cond),
    .pc_src(z_pc_src), .alu_src_a(z_alu_src_a), .alu_src_b(z_alu_src_b), .alu_op(z_alu_op),
    .reg_dst(z_reg_dst), .mem_to_reg(z_mem_to_reg), .reg_write(z_reg_write),
    .illegal(z_illegal), .bus_err(z_bus_err), .busy(z_busy)
`ifdef CONTROL_PERFCNT_EN
   ,.instr_count(z_instr_count), .stall_count(z_stall_count)
`endif
  );

  always #5 clk = ~clk;

  out_t obs;
  assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
                illegal, bus_err, busy};

  int checks = 0;
  int errors = 0;
  logic ill_m = 1'b0, be_m = 1'b0;
  bit ack_in_trap = 1'b1;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic out_t busy_base();
    out_t e;
    e = '0;
    e.busy = 1'b1;
    e.illegal = ill_m;
    e.bus_err = be_m;
    return e;
  endfunction

  // Inputs for the cycle are already applied; check mid-cycle, move to next cycle.
  task automatic cyc(input string tag, input out_t e);
    #1 chk(tag, 32'(obs), 32'(e));
    @(negedge clk);
  endtask

  task automatic trap_hold();
    out_t e;
    for (int i = 0; i < 4; i++) begin
      mem_ack = ack_in_trap ? 1'($urandom_range(0, 1)) : 1'b0;
      e = '0;
      e.illegal = ill_m;
      e.bus_err = be_m;
      cyc("trap", e);
    end
    mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    out_t e;
    reset = 1'b0;
    mem_ack = 1'b0;
    ill_m = 1'b0;
    be_m = 1'b0;
    e = '0;
    cyc("in_reset", e);
    cyc("in_reset", e);
    reset = 1'b1;
    cyc("idle", e);
  endtask

  function automatic bit fn_alu(input logic [5:0] fn, output int aop);
    aop = 0;
    case (fn)
      6'h20: aop = 0;
      6'h22: aop = 1;
      6'h24: aop = 2;
      6'h25: aop = 3;
      6'h2A: aop = 4;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Starts and ends at a negedge with the FSM in its fetch state.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int flat,
                           input int mlat, input logic z, output bit trapped);
    out_t e;
    int aop;
    bit ok;
    trapped = 1'b0;
    op_code = op;
    funct = fn;
    zero = z;
    for (int i = 0; i <= flat; i++) begin
      if (i == TO) begin
        mem_ack = 1'b0;
        be_m = 1'b1;
        trap_hold();
        trapped = 1'b1;
        return;
      end
      mem_ack = (i == flat);
      e = busy_base();
      e.mem_req = 1'b1;
      e.alu_src_b = 2'd1;
      e.ir_write = mem_ack;
      e.pc_write = mem_ack;
      cyc("fetch", e);
    end
    mem_ack = 1'b0;
    e = busy_base();
    e.alu_src_b = 2'd3;
    cyc("decode", e);
    case (op)
      6'h00: begin
        ok = fn_alu(fn, aop);
        e = busy_base();
        e.alu_src_a = 1'b1;
        e.alu_op = 4'(aop);
        cyc("exec_r", e);
        if (!ok) begin
          ill_m = 1'b1;
          trap_hold();
          trapped = 1'b1;
          return;
        end
        e = busy_base();
        e.reg_dst = 1'b1;
        e.reg_write = 1'b1;
        cyc("wb_r", e);
      end
      6'h23, 6'h2B: begin
        e = busy_base();
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'd2;
        cyc("addr", e);
        for (int i = 0; i <= mlat; i++) begin
          mem_ack = (i == mlat);
          e = busy_base();
          e.mem_req = 1'b1;
          e.iord = 1'b1;
          e.mem_we = (op == 6'h2B);
          cyc("mem", e);
        end
        mem_ack = 1'b0;
        if (op == 6'h23) begin
          e = busy_base();
          e.mem_to_reg = 1'b1;
          e.reg_write = 1'b1;
          cyc("wb_mem", e);
        end
      end
      6'h04: begin
        e = busy_base();
        e.alu_src_a = 1'b1;
        e.alu_op = 4'd1;
        e.pc_write_cond = 1'b1;
        e.pc_src = 2'd1;
        cyc("branch", e);
      end
      6'h02: begin
        e = busy_base();
        e.pc_write = 1'b1;
        e.pc_src = 2'd2;
        cyc("jump", e);
      end
      6'h08: begin
        e = busy_base();
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'd2;
        cyc("exec_i", e);
        e = busy_base();
        e.reg_write = 1'b1;
        cyc("wb_i", e);
      end
      default: begin
        ill_m = 1'b1;
        trap_hold();
        trapped = 1'b1;
      end
    endcase
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit tr;
    out_t e;
    logic [5:0] op;
    logic [5:0] fns [5];
    logic [5:0] ops [6];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};

    @(negedge clk);
    do_reset();
    run_instr(6'h00, 6'h20, 2, 0, 1'b0, tr);
    run_instr(6'h23, 6'h00, 0, 0, 1'b0, tr);
    run_instr(6'h23, 6'h00, 1, 5, 1'b0, tr);
    run_instr(6'h2B, 6'h00, 0, 3, 1'b0, tr);
    run_instr(6'h04, 6'h00, 0, 0, 1'b1, tr);
    run_instr(6'h04, 6'h00, 0, 0, 1'b0, tr);
    run_instr(6'h02, 6'h00, 1, 0, 1'b0, tr);
    run_instr(6'h08, 6'h00, 0, 0, 1'b0, tr);
    run_instr(6'h3F, 6'h00, 0, 0, 1'b0, tr);
    chk("trap_op", 32'(tr), 32'd1);
    do_reset();
    run_instr(6'h00, 6'h03, 0, 0, 1'b0, tr);
    chk("trap_fn", 32'(tr), 32'd1);
    do_reset();

    ack_in_trap = 1'b0;
    run_instr(6'h00, 6'h20, 20, 0, 1'b0, tr);
    chk("timeout", 32'(tr), 32'd1);
    chk("no_timeout_wait", 32'({z_busy, z_mem_req, z_bus_err}), 32'b110);
    ack_in_trap = 1'b1;
    do_reset();
    run_instr(6'h00, 6'h20, TO - 1, 0, 1'b0, tr);
    chk("ack_at_limit", 32'(tr), 32'd0);
    run_instr(6'h23, 6'h00, 0, TO - 1, 1'b0, tr);
    chk("mem_ack_at_limit", 32'(tr), 32'd0);

    // Reset asserted between clock edges while a store is outstanding.
    do_reset();
    op_code = 6'h2B;
    mem_ack = 1'b1;
    e = busy_base(); e.mem_req = 1'b1; e.alu_src_b = 2'd1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    cyc("fetch", e);
    mem_ack = 1'b0;
    e = busy_base(); e.alu_src_b = 2'd3;
    cyc("decode", e);
    e = busy_base(); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
    cyc("addr", e);
    #1 chk("sw_pending", 32'({mem_req, mem_we}), 32'b11);
    #2 reset = 1'b0;
    #1 chk("async_drop", 32'({mem_req, mem_we, busy}), 32'b000);
    @(negedge clk);
    do_reset();

`ifdef CONTROL_PERFCNT_EN
    for (int i = 0; i < 3; i++) run_instr(6'h00, 6'h20, 2, 0, 1'b0, tr);
    #1 chk("instr_count", instr_count, 32'd3);
    chk("stall_count", stall_count, 32'd6);
    @(negedge clk);
    do_reset();
`endif

    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 5)];
      run_instr(op, fns[$urandom_range(0, 4)], $urandom_range(0, 6),
                $urandom_range(0, 6), 1'($urandom_range(0, 1)), tr);
      if (tr) do_reset();
    end
    op = 6'h00;
    for (int k = 0; k < 64; k++) begin
      op = 6'($urandom_range(0, 63));
      if (!(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08})) break;
      op = 6'h3E;
    end
    run_instr(op, 6'h20, $urandom_range(0, 4), 0, 1'b0, tr);
    chk("rand_illegal", 32'(tr), 32'd1);
    do_reset();
    run_instr(6'h08, 6'h00, 1, 0, 1'b0, tr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath enables and mux selects, and handshakes with a variable-latency memory through `mem_req`/`mem_ack`.
- Adds bus-timeout detection and an illegal-instruction trap, which the combinational decoder lacks.

Parameters:
- `ALU_OP_W`, 4: width of `alu_op`.
- `MEM_TIMEOUT`, 16: cycles `mem_req` may wait for `mem_ack` before a bus error. 0 disables the timeout.
- `TO_CNT_W`, 5: width of the wait counter. Must satisfy 2^`TO_CNT_W` > `MEM_TIMEOUT`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `op_code`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `mem_ack`  in  1  memory completed the current request this cycle.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write (sw) when `mem_req`=1.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  latch IR.
- `pc_write`  out  1  unconditional PC update.
- `pc_write_cond`  out  1  PC update if `zero`.
- `pc_src`  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- `alu_src_a`  out  1  0 = PC, 1 = rs.
- `alu_src_b`  out  2  0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2.
- `alu_op`  out  `ALU_OP_W`  ALU operation.
- `reg_dst`  out  1  0 = rt, 1 = rd.
- `mem_to_reg`  out  1  0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write.
- `illegal`  out  1  sticky: unknown op_code/funct.
- `bus_err`  out  1  sticky: memory timeout.
- `busy`  out  1  high in every state except `S_IDLE` and `S_TRAP`.

Behaviour:
- Reset (`reset`=0): state `S_IDLE`, wait counter 0, all outputs 0. This holds at any moment, including mid-request; no memory write is issued while in reset.
- Outputs are a Moore decode of the state, except `ir_write`/`pc_write` in `S_FETCH` and completion exits from `S_MEM`, which are qualified by `mem_ack`.

State sequence:
- `S_IDLE` → `S_FETCH` on the first clock after reset releases.
- `S_FETCH`:
  - Always: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=ADD, `pc_src`=0.
  - On `mem_ack`: `ir_write`=1, `pc_write`=1, → `S_DECODE`.
- `S_DECODE`: `alu_src_a`=0, `alu_src_b`=3, `alu_op`=ADD (branch target into ALUOut). Next state by `op_code`:
  - 0x00 R-type → `S_EXEC_R`.
  - 0x23 lw / 0x2B sw → `S_ADDR`.
  - 0x04 beq → `S_BRANCH`.
  - 0x02 j → `S_JUMP`.
  - 0x08 addi → `S_EXEC_I`.
  - Any other op_code → `S_TRAP` with `illegal` set.
- `S_EXEC_R`: `alu_src_a`=1, `alu_src_b`=0, `alu_op` from `funct`: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT. Any other `funct` → `S_TRAP`, `illegal`=1. Otherwise → `S_WB_R`.
- `S_WB_R`: `reg_dst`=1, `mem_to_reg`=0, `reg_write`=1 → `S_FETCH`.
- `S_EXEC_I`: `alu_src_a`=1, `alu_src_b`=2, ADD → `S_WB_I`.
- `S_WB_I`: `reg_dst`=0, `reg_write`=1 → `S_FETCH`.
- `S_ADDR`: `alu_src_a`=1, `alu_src_b`=2, ADD → `S_MEM`.
- `S_MEM`: `mem_req`=1, `iord`=1, `mem_we`=(op==sw). On `mem_ack`: lw → `S_WB_MEM`, sw → `S_FETCH`.
- `S_WB_MEM`: `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1 → `S_FETCH`.
- `S_BRANCH`: `alu_src_a`=1, `alu_src_b`=0, SUB, `pc_write_cond`=1, `pc_src`=1 → `S_FETCH`.
- `S_JUMP`: `pc_write`=1, `pc_src`=2 → `S_FETCH`.
- `S_TRAP`: all enables 0; the FSM stays here until reset.

Memory wait and timeout:
- The wait counter clears on entry to `S_FETCH`/`S_MEM` and increments each cycle `mem_req`=1 and `mem_ack`=0.
- If `MEM_TIMEOUT`≠0 and the counter reaches `MEM_TIMEOUT` → `S_TRAP`, `bus_err`=1.
- A `mem_ack` in the same cycle the counter reaches `MEM_TIMEOUT` counts as success; ack wins.
- `mem_ack` while `mem_req`=0 is ignored.

Optional Feature:
- Macro: `CONTROL_PERFCNT_EN`.
- With the macro defined:
  - Extra outputs `instr_count` [31:0] and `stall_count` [31:0], both reset to 0.
  - `instr_count` increments on each transition into `S_FETCH` from a non-`S_IDLE` state.
  - `stall_count` increments each cycle `mem_req`=1 and `mem_ack`=0.
  - Both wrap at 2^32 and freeze in `S_TRAP`.
- Without the macro: these ports and their logic do not exist.

Decomposition:
- Shared package `mips_pkg`:
  - State enum.
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI.
  - Funct constants.
  - ALU op encodings: ADD=0, SUB=1, AND=2, OR=3, SLT=4.
  - `pc_src`/`alu_src_b` select constants.
- Sub-module `alu_decode`: purely combinational `funct` → {`alu_op`, valid}, reused by the pipelined core later.

Test Plan:
- Release reset, assert `mem_ack` on the 3rd `S_FETCH` cycle, IR = add (op 0, funct 0x20) → `ir_write` and `pc_write` pulse in the ack cycle; `reg_write`=1 with `reg_dst`=1 exactly 3 cycles after the ack; `alu_op`=0 in `S_EXEC_R`.
- lw (0x23) with 0-cycle and 5-cycle ack in `S_MEM` → `iord`=1, `mem_we`=0, then `mem_to_reg`=1 and `reg_write`=1; sw (0x2B) → `mem_we`=1, returns to `S_FETCH` with no `reg_write`.
- beq with `zero`=1 and then `zero`=0 → `pc_write_cond`=1 and `pc_src`=1 in both cases, one cycle, then `S_FETCH`; j → `pc_write`=1, `pc_src`=2.
- op_code 0x3F, and R-type with `funct` 0x03 → `illegal`=1, `busy`=0, no further `mem_req`; deassert then release reset → `illegal`=0, fetch resumes.
- `mem_ack` withheld with `MEM_TIMEOUT`=16 → `bus_err`=1 after exactly 16 wait cycles; with ack in cycle 16 → no error; with `MEM_TIMEOUT`=0 → wait indefinitely.
- Assert reset mid-`S_MEM` with `mem_we`=1 → `mem_we`/`mem_req` drop to 0 immediately (asynchronously); with `CONTROL_PERFCNT_EN`, 3 instructions with 2 stalls each → `instr_count`=3, `stall_count`=6.
